// File: rtl/dh_pkg.sv
// Shared types and defaults for the duck-hunt gun path.
package dh_pkg;

    typedef enum logic [2:0] {
        GS_IDLE     = 3'd0,
        GS_ARM      = 3'd1,
        GS_DARK     = 3'd2,
        GS_TARGET   = 3'd3,
        GS_EVAL     = 3'd4,
        GS_COOLDOWN = 3'd5
    } gun_state_t;

    // 1 ms at the 65 MHz pixel clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 65000;
    localparam int unsigned COOLDOWN_FRAMES_DEF = 15;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gun_debounce.sv
// Two-flop synchroniser, level debouncer and press-edge detector for one
// raw button input. A level held through reset is not reported as a press
// until the input has been seen released.
module gun_debounce
    import dh_pkg::*;
#(
    parameter int unsigned CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic press_o
);

    localparam int unsigned CNT_W = cnt_width(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = (CYCLES > 0) ? CNT_W'(CYCLES - 1) : '0;
    // Quiet window covers the debounce time plus the two synchroniser
    // stages, which read 0 straight out of reset even if the input is held.
    localparam int unsigned QUIET = CYCLES + 2;
    localparam int unsigned QW = cnt_width(QUIET);
    localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             prev_q;
    logic             block_q, block_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [QW-1:0]    quiet_q, quiet_d;

    // Synchronise the asynchronous raw input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
        end
    end

    // Debounce counter, quiet-time counter and post-reset press blocking.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (sync_q[1]) begin
            quiet_d = '0;
        end else if (quiet_q != QUIET_MAX) begin
            quiet_d = quiet_q + 1'b1;
        end else begin
            quiet_d = quiet_q;
        end

        block_d = block_q && (quiet_q != QUIET_MAX);
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            block_q <= 1'b1;
            cnt_q   <= '0;
            quiet_q <= '0;
        end else begin
            level_q <= level_d;
            prev_q  <= level_q;
            block_q <= block_d;
            cnt_q   <= cnt_d;
            quiet_q <= quiet_d;
        end
    end

    assign press_o = level_q & ~prev_q & ~block_q;

endmodule

// File: rtl/gun_ctl.sv
// Light-gun controller: accepts a debounced trigger press, runs a black
// frame then a white-target frame, and scores the photodetector readings.
module gun_ctl
    import dh_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
    parameter logic        PD_ACTIVE       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic new_frame,
    input  logic duck_show,
    input  logic gun_trigger,
    input  logic gun_photodetector,
    output logic flash_bg,
    output logic flash_target,
    output logic duck_hit,
    output logic shot_fired,
    output logic busy
);

    localparam int unsigned CD_W = cnt_width(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    logic            press;
    logic [1:0]      pd_sync_q;
    logic            pd_seen;
    gun_state_t      state_q, state_d;
    logic            armed_show_q, armed_show_d;
    logic            light_dark_q, light_dark_d;
    logic            light_tgt_q, light_tgt_d;
    logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
    logic            flash_bg_q, flash_bg_d;
    logic            flash_tgt_q, flash_tgt_d;
    logic            hit_q, hit_d;
    logic            shot_q, shot_d;
    logic            busy_q, busy_d;

    gun_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_trigger (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (gun_trigger),
        .press_o(press)
    );

    // Synchronise the photodetector; no debounce, short flashes matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pd_sync_q <= '0;
        end else begin
            pd_sync_q <= {pd_sync_q[0], gun_photodetector};
        end
    end

    assign pd_seen = (pd_sync_q[1] == PD_ACTIVE);

    // Flash sequence FSM; outputs are derived from the next state so they
    // change on the same edge as the state.
    always_comb begin
        state_d      = state_q;
        armed_show_d = armed_show_q;
        light_dark_d = light_dark_q;
        light_tgt_d  = light_tgt_q;
        cd_cnt_d     = cd_cnt_q;
        hit_d        = 1'b0;
        shot_d       = 1'b0;

        case (state_q)
            GS_IDLE: begin
                if (press) begin
                    shot_d       = 1'b1;
                    armed_show_d = duck_show;
                    state_d      = GS_ARM;
                end
            end
            GS_ARM: begin
                if (new_frame) begin
                    light_dark_d = 1'b0;
                    state_d      = GS_DARK;
                end
            end
            GS_DARK: begin
                light_dark_d = light_dark_q | pd_seen;
                if (new_frame) begin
                    light_tgt_d = 1'b0;
                    state_d     = GS_TARGET;
                end
            end
            GS_TARGET: begin
                light_tgt_d = light_tgt_q | pd_seen;
                if (new_frame) begin
                    // Registered here so the pulse coincides with EVAL.
                    hit_d   = armed_show_q & ~light_dark_q & light_tgt_d;
                    state_d = GS_EVAL;
                end
            end
            GS_EVAL: begin
                cd_cnt_d = CD_LOAD;
                state_d  = GS_COOLDOWN;
            end
            GS_COOLDOWN: begin
                if (cd_cnt_q == '0) begin
                    state_d = GS_IDLE;
                end else if (new_frame) begin
                    cd_cnt_d = cd_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = GS_IDLE;
            end
        endcase

        flash_bg_d  = (state_d == GS_DARK) || (state_d == GS_TARGET);
        flash_tgt_d = (state_d == GS_TARGET);
        busy_d      = (state_d != GS_IDLE);
    end

    // FSM state, flags and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= GS_IDLE;
            armed_show_q <= 1'b0;
            light_dark_q <= 1'b0;
            light_tgt_q  <= 1'b0;
            cd_cnt_q     <= '0;
            flash_bg_q   <= 1'b0;
            flash_tgt_q  <= 1'b0;
            hit_q        <= 1'b0;
            shot_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_show_q <= armed_show_d;
            light_dark_q <= light_dark_d;
            light_tgt_q  <= light_tgt_d;
            cd_cnt_q     <= cd_cnt_d;
            flash_bg_q   <= flash_bg_d;
            flash_tgt_q  <= flash_tgt_d;
            hit_q        <= hit_d;
            shot_q       <= shot_d;
            busy_q       <= busy_d;
        end
    end

    assign flash_bg     = flash_bg_q;
    assign flash_target = flash_tgt_q;
    assign duck_hit     = hit_q;
    assign shot_fired   = shot_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_gun_ctl.sv
// Scoreboard bench for gun_ctl: stimulus queues expected pulses and flash
// windows, a monitor pops them as the DUT produces them.
module tb_gun_ctl;

    logic clk = 1'b0;
    logic rst;
    logic new_frame;
    logic duck_show;
    logic gun_trigger;
    logic gun_photodetector;
    logic flash_bg;
    logic flash_target;
    logic duck_hit;
    logic shot_fired;
    logic busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int start;
        int len;
    } run_t;

    int   exp_shot[$];
    int   exp_hit[$];
    run_t exp_bg[$];
    run_t exp_tgt[$];

    gun_ctl #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_FRAMES(2),
        .PD_ACTIVE      (1'b1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .new_frame        (new_frame),
        .duck_show        (duck_show),
        .gun_trigger      (gun_trigger),
        .gun_photodetector(gun_photodetector),
        .flash_bg         (flash_bg),
        .flash_target     (flash_target),
        .duck_hit         (duck_hit),
        .shot_fired       (shot_fired),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // new_frame sampled high on posedges 100, 200, 300, ...
    initial begin
        new_frame = 1'b0;
        forever begin
            @(negedge clk);
            new_frame = (((cyc + 1) % 100) == 0);
        end
    end

    // Monitor
    logic bg_prev  = 1'b0;
    logic tgt_prev = 1'b0;
    int   bg_start  = 0;
    int   tgt_start = 0;
    run_t r;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (shot_fired === 1'b1) begin
                if (exp_shot.size() == 0) chk("shot_unexpected", cyc, -1);
                else chk("shot_cycle", cyc, exp_shot.pop_front());
            end
            if (duck_hit === 1'b1) begin
                if (exp_hit.size() == 0) chk("hit_unexpected", cyc, -1);
                else chk("hit_cycle", cyc, exp_hit.pop_front());
            end
            if (flash_bg && !bg_prev) bg_start = cyc;
            if (!flash_bg && bg_prev) begin
                if (exp_bg.size() == 0) chk("bg_unexpected", cyc, -1);
                else begin
                    r = exp_bg.pop_front();
                    chk("bg_start", bg_start, r.start);
                    chk("bg_len", cyc - bg_start, r.len);
                end
            end
            bg_prev = flash_bg;
            if (flash_target && !tgt_prev) tgt_start = cyc;
            if (!flash_target && tgt_prev) begin
                if (exp_tgt.size() == 0) chk("tgt_unexpected", cyc, -1);
                else begin
                    r = exp_tgt.pop_front();
                    chk("tgt_start", tgt_start, r.start);
                    chk("tgt_len", cyc - tgt_start, r.len);
                end
            end
            tgt_prev = flash_target;
        end
    end

    // Watchdog
    initial begin
        #60000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        rst               = 1'b1;
        duck_show         = 1'b0;
        gun_trigger       = 1'b0;
        gun_photodetector = 1'b0;

        goto(1);
        #2;
        chk("rst_flash_bg", int'(flash_bg), 0);
        chk("rst_flash_target", int'(flash_target), 0);
        chk("rst_duck_hit", int'(duck_hit), 0);
        chk("rst_shot_fired", int'(shot_fired), 0);
        chk("rst_busy", int'(busy), 0);

        goto(2);
        rst       = 1'b0;
        duck_show = 1'b1;

        // 3-cycle glitch: rejected
        goto(20); gun_trigger = 1'b1;
        goto(23); gun_trigger = 1'b0;
        goto(35); #1;
        chk("glitch_busy", int'(busy), 0);

        // Hit: press at 40 -> shot at 47, DARK 100..299, TARGET 200..299, hit 300
        exp_shot.push_back(47);
        exp_bg.push_back('{start: 100, len: 200});
        exp_tgt.push_back('{start: 200, len: 100});
        exp_hit.push_back(300);
        goto(40); gun_trigger = 1'b1;
        goto(50); gun_trigger = 1'b0;
        goto(60); #1;
        chk("armed_busy", int'(busy), 1);
        goto(220); gun_trigger = 1'b1;          // press during TARGET: dropped
        goto(230); gun_trigger = 1'b0;
        goto(250); gun_photodetector = 1'b1;
        goto(255); gun_photodetector = 1'b0;
        goto(350); gun_trigger = 1'b1;          // press during COOLDOWN: dropped
        goto(360); gun_trigger = 1'b0;
        #1;
        chk("cooldown_busy", int'(busy), 1);

        // Lamp reject: light present in both frames
        exp_shot.push_back(517);
        exp_bg.push_back('{start: 600, len: 200});
        exp_tgt.push_back('{start: 700, len: 100});
        goto(510); gun_trigger = 1'b1;
        goto(520); gun_trigger = 1'b0; gun_photodetector = 1'b1;
        goto(810); gun_photodetector = 1'b0;

        // Miss: no light at all
        exp_shot.push_back(1017);
        exp_bg.push_back('{start: 1100, len: 200});
        exp_tgt.push_back('{start: 1200, len: 100});
        goto(1010); gun_trigger = 1'b1;
        goto(1020); gun_trigger = 1'b0;

        // duck_show low at acceptance, raised afterwards: no hit
        goto(1505); duck_show = 1'b0;
        exp_shot.push_back(1517);
        exp_bg.push_back('{start: 1600, len: 200});
        exp_tgt.push_back('{start: 1700, len: 100});
        goto(1510); gun_trigger = 1'b1;
        goto(1520); gun_trigger = 1'b0;
        goto(1550); duck_show = 1'b1;
        goto(1750); gun_photodetector = 1'b1;
        goto(1755); gun_photodetector = 1'b0;

        // Reset mid-DARK with the trigger held through it
        exp_shot.push_back(2017);
        exp_bg.push_back('{start: 2100, len: 50});
        goto(2010); gun_trigger = 1'b1;
        goto(2150); rst = 1'b1;
        #2;
        chk("midrst_flash_bg", int'(flash_bg), 0);
        chk("midrst_flash_target", int'(flash_target), 0);
        chk("midrst_duck_hit", int'(duck_hit), 0);
        chk("midrst_shot_fired", int'(shot_fired), 0);
        chk("midrst_busy", int'(busy), 0);
        goto(2153); rst = 1'b0;
        goto(2195); #1;
        chk("held_trigger_busy", int'(busy), 0);
        goto(2200); gun_trigger = 1'b0;

        // Re-press after release: accepted and hits
        exp_shot.push_back(2227);
        exp_bg.push_back('{start: 2300, len: 200});
        exp_tgt.push_back('{start: 2400, len: 100});
        exp_hit.push_back(2500);
        goto(2220); gun_trigger = 1'b1;
        goto(2230); gun_trigger = 1'b0;
        goto(2450); gun_photodetector = 1'b1;
        goto(2455); gun_photodetector = 1'b0;

        goto(2750); #3;
        chk("pending_shot", exp_shot.size(), 0);
        chk("pending_hit", exp_hit.size(), 0);
        chk("pending_bg", exp_bg.size(), 0);
        chk("pending_tgt", exp_tgt.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
